// File: rtl/h_bridge_pkg.sv
// Shared types and constants for the six-step H-bridge commutation sequencer.
// Switch vectors are ordered bit 0 = sw1 (A), bit 1 = sw2 (B), bit 2 = sw3 (C).
package h_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DEAD  = 2'd1,
        DRIVE = 2'd2,
        FAULT = 2'd3
    } state_t;

    localparam logic [2:0] STEP_MAX = 3'd5;

    // {p[2:0], n[2:0]} per step, leftmost entry is step 5:
    // 0 A+B-, 1 A+C-, 2 B+C-, 3 B+A-, 4 C+A-, 5 C+B-
    localparam logic [5:0][5:0] STEP_TABLE = {
        6'b100_010,
        6'b100_001,
        6'b010_001,
        6'b010_100,
        6'b001_100,
        6'b001_010
    };

endpackage

// File: rtl/h_bridge_commutation_sequencer_decode.sv
// Combinational step index to high/low switch pattern; codes 6 and 7 are all off.
module commutation_step_decode
    import h_bridge_pkg::*;
(
    input  logic [2:0] step,
    output logic [2:0] p,
    output logic [2:0] n
);

    always_comb begin
        p = '0;
        n = '0;
        if (step <= STEP_MAX) begin
            {p, n} = STEP_TABLE[step];
        end
    end

endmodule

// File: rtl/h_bridge_commutation_sequencer.sv
// Six-step commutation FSM with dead-time insertion, enable gating and latched fault.
// Outputs are registered from the next-state values so they track the state after each edge.
module h_bridge_commutation_sequencer
    import h_bridge_pkg::*;
#(
    parameter int DEADTIME_CYC = 50,
    parameter int PERIOD_W     = 24,
    parameter int DT_W         = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                dir,
    input  logic [PERIOD_W-1:0] step_period,
    input  logic                fault,
    output logic                sw1_p,
    output logic                sw1_n,
    output logic                sw2_p,
    output logic                sw2_n,
    output logic                sw3_p,
    output logic                sw3_n,
    output logic [2:0]          step,
    output logic                driving,
    output logic                fault_lat
);

    localparam logic [DT_W-1:0] DT_LOAD = DT_W'(DEADTIME_CYC);

    state_t              state_reg, state_next;
    logic [2:0]          step_reg, step_next;
    logic [DT_W-1:0]     dt_reg, dt_next;
    logic [PERIOD_W-1:0] per_reg, per_next;
    logic [2:0]          p_reg, n_reg;
    logic [2:0]          dec_p, dec_n;
    logic [2:0]          step_adv;

    always_comb begin
        if (dir) begin
            step_adv = (step_reg >= STEP_MAX) ? 3'd0 : step_reg + 3'd1;
        end else begin
            step_adv = (step_reg == 3'd0) ? STEP_MAX : step_reg - 3'd1;
        end
    end

    always_comb begin
        state_next = state_reg;
        step_next  = step_reg;
        dt_next    = dt_reg;
        per_next   = per_reg;
        if (fault) begin
            state_next = FAULT;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (enable) begin
                        state_next = DEAD;
                        dt_next    = DT_LOAD;
                    end
                end
                DEAD: begin
                    if (!enable) begin
                        state_next = IDLE;
                    end else if (dt_reg <= 1) begin
                        // dead interval spans exactly DT_LOAD cycles; period sampled only here
                        state_next = DRIVE;
                        dt_next    = '0;
                        per_next   = step_period;
                    end else begin
                        dt_next = dt_reg - 1'b1;
                    end
                end
                DRIVE: begin
                    if (!enable) begin
                        state_next = IDLE;
                    end else if (per_reg == '0) begin
                        state_next = DRIVE;
                    end else if (per_reg == 1) begin
                        state_next = DEAD;
                        step_next  = step_adv;
                        dt_next    = DT_LOAD;
                        per_next   = '0;
                    end else begin
                        per_next = per_reg - 1'b1;
                    end
                end
                FAULT: begin
                    if (!enable) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    commutation_step_decode u_decode (
        .step (step_next),
        .p    (dec_p),
        .n    (dec_n)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            step_reg  <= '0;
            dt_reg    <= '0;
            per_reg   <= '0;
            p_reg     <= '0;
            n_reg     <= '0;
            driving   <= 1'b0;
            fault_lat <= 1'b0;
        end else begin
            state_reg <= state_next;
            step_reg  <= step_next;
            dt_reg    <= dt_next;
            per_reg   <= per_next;
            p_reg     <= (state_next == DRIVE) ? dec_p : 3'b000;
            n_reg     <= (state_next == DRIVE) ? dec_n : 3'b000;
            driving   <= (state_next == DRIVE);
            fault_lat <= (state_next == FAULT);
        end
    end

    assign sw1_p = p_reg[0];
    assign sw2_p = p_reg[1];
    assign sw3_p = p_reg[2];
    assign sw1_n = n_reg[0];
    assign sw2_n = n_reg[1];
    assign sw3_n = n_reg[2];
    assign step  = step_reg;

endmodule

// File: tb/tb_h_bridge_commutation_sequencer.sv
// Bench for the commutation sequencer: cycle model from the behavioural rules,
// per-cycle comparison with switch-safety checks, directed scenarios and random phase.
module tb_h_bridge_commutation_sequencer;

    localparam int DT      = 50;
    localparam int M_IDLE  = 0;
    localparam int M_DEAD  = 1;
    localparam int M_DRIVE = 2;
    localparam int M_FAULT = 3;

    typedef struct {
        int mode;
        int step;
        int off;
        int drv;
        bit hold;
    } mstate_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        dir = 1'b1;
    logic        fault = 1'b0;
    logic [23:0] step_period = '0;
    logic        sw1_p, sw1_n, sw2_p, sw2_n, sw3_p, sw3_n;
    logic [2:0]  step;
    logic        driving, fault_lat;

    int n_tests = 0;
    int n_fail  = 0;

    // high-side and low-side phase used by each step
    int hi_sw[6] = '{0, 0, 1, 1, 2, 2};
    int lo_sw[6] = '{1, 2, 2, 0, 0, 1};

    mstate_t     m;
    int          off_run = 0;
    logic [5:0]  prev_on = '0;

    h_bridge_commutation_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .dir         (dir),
        .step_period (step_period),
        .fault       (fault),
        .sw1_p       (sw1_p),
        .sw1_n       (sw1_n),
        .sw2_p       (sw2_p),
        .sw2_n       (sw2_n),
        .sw3_p       (sw3_p),
        .sw3_n       (sw3_n),
        .step        (step),
        .driving     (driving),
        .fault_lat   (fault_lat)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic mstate_t model_next(mstate_t s, bit f, bit en, bit d, int per);
        mstate_t r = s;
        if (f) begin
            r.mode = M_FAULT;
        end else begin
            case (s.mode)
                M_IDLE: if (en) begin
                    r.mode = M_DEAD;
                    r.off  = DT;
                end
                M_DEAD: if (!en) begin
                    r.mode = M_IDLE;
                end else begin
                    r.off = s.off - 1;
                    if (r.off == 0) begin
                        r.mode = M_DRIVE;
                        r.drv  = per;
                        r.hold = (per == 0);
                    end
                end
                M_DRIVE: if (!en) begin
                    r.mode = M_IDLE;
                end else if (!s.hold) begin
                    r.drv = s.drv - 1;
                    if (r.drv == 0) begin
                        r.step = (s.step + (d ? 1 : 5)) % 6;
                        r.mode = M_DEAD;
                        r.off  = DT;
                    end
                end
                M_FAULT: if (!en) r.mode = M_IDLE;
                default: r.mode = M_IDLE;
            endcase
        end
        return r;
    endfunction

    // reference model, advanced on each active edge; async reset clears it at once
    initial begin
        m = '{M_IDLE, 0, 0, 0, 1'b0};
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) m = '{M_IDLE, 0, 0, 0, 1'b0};
            else        m = model_next(m, fault, enable, dir, int'(step_period));
        end
    end

    // per-cycle comparison and switch-safety checks, sampled mid-cycle
    initial begin
        logic [2:0] ep, en_, p_now, n_now;
        forever begin
            @(negedge clk);
            ep  = '0;
            en_ = '0;
            if (m.mode == M_DRIVE) begin
                ep[hi_sw[m.step]]  = 1'b1;
                en_[lo_sw[m.step]] = 1'b1;
            end
            p_now = {sw3_p, sw2_p, sw1_p};
            n_now = {sw3_n, sw2_n, sw1_n};
            check("model_sw_p", int'(p_now), int'(ep));
            check("model_sw_n", int'(n_now), int'(en_));
            check("model_step", int'(step), m.step);
            check("model_driving", int'(driving), int'(m.mode == M_DRIVE));
            check("model_fault_lat", int'(fault_lat), int'(m.mode == M_FAULT));
            check("shoot_through", int'(|(p_now & n_now)), 0);
            check("single_high", int'($countones(p_now) <= 1), 1);
            check("single_low", int'($countones(n_now) <= 1), 1);
            if (({p_now, n_now} & ~prev_on) != 6'b0) begin
                check("deadtime_before_on", int'(off_run >= DT), 1);
            end
            if ({p_now, n_now} == 6'b0) off_run++;
            else                        off_run = 0;
            prev_on = {p_now, n_now};
        end
    end

    task automatic tick(input int cycles);
        repeat (cycles) @(posedge clk);
        #2;
    endtask

    task automatic chk_out(input string tag, input int st, input bit drv,
                           input logic [2:0] p, input logic [2:0] n);
        @(negedge clk);
        $display("[TB] %s: step=%0d driving=%0d p=%b n=%b fault_lat=%0d",
                 tag, step, driving, {sw3_p, sw2_p, sw1_p}, {sw3_n, sw2_n, sw1_n}, fault_lat);
        check({tag, "_step"}, int'(step), st);
        check({tag, "_driving"}, int'(driving), int'(drv));
        check({tag, "_p"}, int'({sw3_p, sw2_p, sw1_p}), int'(p));
        check({tag, "_n"}, int'({sw3_n, sw2_n, sw1_n}), int'(n));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(5);
        rst_n = 1'b1;
    endtask

    initial begin
        // reset held with enable high
        rst_n = 1'b0; enable = 1'b1; dir = 1'b1; step_period = 24'd1000; fault = 1'b0;
        tick(5);
        chk_out("reset", 0, 1'b0, 3'b000, 3'b000);
        check("reset_fault_lat", int'(fault_lat), 0);
        rst_n = 1'b1;

        // forward run
        tick(50);   chk_out("fwd_dead", 0, 1'b0, 3'b000, 3'b000);
        tick(1);    chk_out("fwd_s0", 0, 1'b1, 3'b001, 3'b010);
        tick(999);  chk_out("fwd_s0_end", 0, 1'b1, 3'b001, 3'b010);
        tick(1);    chk_out("fwd_adv1", 1, 1'b0, 3'b000, 3'b000);
        tick(50);   chk_out("fwd_s1", 1, 1'b1, 3'b001, 3'b100);
        tick(5260); chk_out("fwd_wrap_s0", 0, 1'b1, 3'b001, 3'b010);

        // enable gating in step 3
        tick(3640); chk_out("gate_s3", 3, 1'b1, 3'b010, 3'b001);
        enable = 1'b0;
        tick(1);    chk_out("gate_off", 3, 1'b0, 3'b000, 3'b000);
        tick(19);
        enable = 1'b1;
        tick(50);   chk_out("gate_dead", 3, 1'b0, 3'b000, 3'b000);
        tick(1);    chk_out("gate_resume", 3, 1'b1, 3'b010, 3'b001);
        tick(999);  chk_out("gate_full_period", 3, 1'b1, 3'b010, 3'b001);
        tick(1);    chk_out("gate_adv4", 4, 1'b0, 3'b000, 3'b000);

        // asynchronous reset mid-operation
        rst_n = 1'b0;
        chk_out("async_reset", 0, 1'b0, 3'b000, 3'b000);
        dir = 1'b0; step_period = 24'd100;
        tick(4);
        rst_n = 1'b1;

        // reverse wrap
        tick(51);   chk_out("rev_s0", 0, 1'b1, 3'b001, 3'b010);
        tick(100);  chk_out("rev_adv5", 5, 1'b0, 3'b000, 3'b000);
        tick(50);   chk_out("rev_s5", 5, 1'b1, 3'b100, 3'b010);
        tick(150);  chk_out("rev_s4", 4, 1'b1, 3'b100, 3'b001);

        // hold with zero period
        rst_n = 1'b0; dir = 1'b1; step_period = 24'd0;
        tick(5);
        rst_n = 1'b1;
        tick(51);   chk_out("hold_start", 0, 1'b1, 3'b001, 3'b010);
        tick(2000); chk_out("hold_end", 0, 1'b1, 3'b001, 3'b010);

        // single-cycle fault pulse in DRIVE
        fault = 1'b1;
        tick(1);
        fault = 1'b0;
        chk_out("fault_hit", 0, 1'b0, 3'b000, 3'b000);
        check("fault_lat_set", int'(fault_lat), 1);
        tick(30);   chk_out("fault_held", 0, 1'b0, 3'b000, 3'b000);
        check("fault_lat_held", int'(fault_lat), 1);
        enable = 1'b0;
        tick(1);    chk_out("fault_clear", 0, 1'b0, 3'b000, 3'b000);
        check("fault_lat_clear", int'(fault_lat), 0);
        enable = 1'b1;
        tick(50);   chk_out("fault_restart_dead", 0, 1'b0, 3'b000, 3'b000);
        tick(1);    chk_out("fault_restart_drive", 0, 1'b1, 3'b001, 3'b010);

        // randomized phase against the model
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            tick(1);
            rst_n       = ($urandom_range(0, 1999) != 0);
            fault       = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 149) == 0) enable = ~enable;
            dir         = 1'($urandom);
            step_period = 24'($urandom_range(0, 40));
        end
        rst_n = 1'b1; fault = 1'b0;
        tick(2);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
